// File: rtl/red_pitaya_haze_limiter.sv
// Output limiter for the haze mixing stage: clamps samples to [MIN, MAX] with an optional
// slew limit, a BYPASS/TRACK/HOLD mode machine and saturation statistics on a simple bus.
module red_pitaya_haze_limiter #(
  parameter int unsigned CNTBITS  = 16,
  parameter int unsigned STEPBITS = 13
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic signed [13:0] dat_i,
  output logic signed [13:0] dat_o,
  input  logic        [15:0] addr,
  input  logic               wen,
  input  logic               ren,
  output logic               ack,
  output logic        [31:0] rdata,
  input  logic        [31:0] wdata
);

  localparam logic [15:0] AddrMin    = 16'h0100;
  localparam logic [15:0] AddrMax    = 16'h0104;
  localparam logic [15:0] AddrStep   = 16'h0108;
  localparam logic [15:0] AddrCtrl   = 16'h010C;
  localparam logic [15:0] AddrStatus = 16'h0110;

  localparam logic [CNTBITS-1:0] CntOne = {{(CNTBITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StBypass = 2'd0,
    StTrack  = 2'd1,
    StHold   = 2'd2
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic signed [13:0]    r_min;
  logic signed [13:0]    r_max;
  logic [STEPBITS-1:0]   r_step;
  logic                  r_enable;
  logic                  r_hold;
  logic                  r_hi;
  logic                  r_lo;
  logic [CNTBITS-1:0]    r_cnt;
  logic signed [13:0]    r_dat;
  logic                  r_ack;
  logic [31:0]           r_rdata;

  logic                  w_wr_min;
  logic                  w_wr_max;
  logic                  w_wr_step;
  logic                  w_wr_ctrl;
  logic                  w_clear;
  logic                  w_evt_hi;
  logic                  w_evt_lo;
  logic [31:0]           w_rd_mux;
  logic                  w_unused;

  logic signed [15:0]    w_din;
  logic signed [15:0]    w_min;
  logic signed [15:0]    w_max;
  logic signed [15:0]    w_out;
  logic signed [15:0]    w_step;
  logic signed [15:0]    w_tgt;
  logic signed [15:0]    w_up;
  logic signed [15:0]    w_dn;
  logic signed [15:0]    w_lim;
  logic signed [15:0]    w_dat_nxt;

  assign w_wr_min  = wen && (addr == AddrMin);
  assign w_wr_max  = wen && (addr == AddrMax);
  assign w_wr_step = wen && (addr == AddrStep);
  assign w_wr_ctrl = wen && (addr == AddrCtrl);
  assign w_clear   = w_wr_ctrl && wdata[2];
  assign w_unused  = ^wdata[31:14];

  // Widen to 16 bits so slew steps near full scale never wrap.
  assign w_din  = 16'(dat_i);
  assign w_min  = 16'(r_min);
  assign w_max  = 16'(r_max);
  assign w_out  = 16'(r_dat);
  assign w_step = signed'({{(16 - STEPBITS){1'b0}}, r_step});
  assign w_up   = w_out + w_step;
  assign w_dn   = w_out - w_step;

  assign w_evt_hi = (r_state != StBypass) && (w_din > w_max);
  assign w_evt_lo = (r_state != StBypass) && (w_din < w_min);

  always_comb begin
    // MAX is applied last so an inverted window collapses onto MAX.
    w_tgt = w_din;
    if (w_tgt < w_min) w_tgt = w_min;
    if (w_tgt > w_max) w_tgt = w_max;

    w_lim = w_tgt;
    if (r_step != '0) begin
      if (w_tgt > w_up) begin
        w_lim = w_up;
      end else if (w_tgt < w_dn) begin
        w_lim = w_dn;
      end
    end
    if (w_lim < w_min) w_lim = w_min;
    if (w_lim > w_max) w_lim = w_max;

    case (r_state)
      StTrack: w_dat_nxt = w_lim;
      StHold:  w_dat_nxt = w_out;
      default: w_dat_nxt = w_din;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StBypass: begin
        if (r_enable) w_state_nxt = r_hold ? StHold : StTrack;
      end
      StTrack: begin
        if (!r_enable)  w_state_nxt = StBypass;
        else if (r_hold) w_state_nxt = StHold;
      end
      StHold: begin
        if (!r_enable)   w_state_nxt = StBypass;
        else if (!r_hold) w_state_nxt = StTrack;
      end
      default: w_state_nxt = StBypass;
    endcase
  end

  always_comb begin
    w_rd_mux = '0;
    case (addr)
      AddrMin:    w_rd_mux = {{18{r_min[13]}}, r_min};
      AddrMax:    w_rd_mux = {{18{r_max[13]}}, r_max};
      AddrStep:   w_rd_mux[STEPBITS-1:0] = r_step;
      AddrCtrl:   w_rd_mux[1:0] = {r_hold, r_enable};
      AddrStatus: begin
        w_rd_mux[1:0]           = r_state;
        w_rd_mux[2]             = r_hi;
        w_rd_mux[3]             = r_lo;
        w_rd_mux[16 +: CNTBITS] = r_cnt;
      end
      default:    w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= StBypass;
      r_min    <= 14'sh2000;
      r_max    <= 14'sh1FFF;
      r_step   <= '0;
      r_enable <= 1'b0;
      r_hold   <= 1'b0;
      r_dat    <= '0;
      r_ack    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dat   <= w_dat_nxt[13:0];
      r_ack   <= wen | ren;
      r_rdata <= ren ? w_rd_mux : '0;
      if (w_wr_min)  r_min  <= wdata[13:0];
      if (w_wr_max)  r_max  <= wdata[13:0];
      if (w_wr_step) r_step <= wdata[STEPBITS-1:0];
      if (w_wr_ctrl) begin
        r_enable <= wdata[0];
        r_hold   <= wdata[1];
      end
    end
  end

  // CLEAR has priority over a coincident saturation event.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_hi  <= 1'b0;
      r_lo  <= 1'b0;
      r_cnt <= '0;
    end else if (w_clear) begin
      r_hi  <= 1'b0;
      r_lo  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_evt_hi) r_hi <= 1'b1;
      if (w_evt_lo) r_lo <= 1'b1;
      if ((w_evt_hi || w_evt_lo) && !(&r_cnt)) r_cnt <= r_cnt + CntOne;
    end
  end

  assign dat_o = r_dat;
  assign ack   = r_ack;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_red_pitaya_haze_limiter.sv
// Randomised and directed bench for red_pitaya_haze_limiter against a cycle-level integer model.
module tb_red_pitaya_haze_limiter;

  localparam int unsigned CntBits  = 4;
  localparam int unsigned StepBits = 13;
  localparam int          CntMax   = (1 << CntBits) - 1;

  logic               clk_i = 1'b0;
  logic               rstn_i;
  logic signed [13:0] dat_i;
  logic signed [13:0] dat_o;
  logic        [15:0] addr;
  logic               wen;
  logic               ren;
  logic               ack;
  logic        [31:0] rdata;
  logic        [31:0] wdata;

  red_pitaya_haze_limiter #(
    .CNTBITS  (CntBits),
    .STEPBITS (StepBits)
  ) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .dat_i  (dat_i),
    .dat_o  (dat_o),
    .addr   (addr),
    .wen    (wen),
    .ren    (ren),
    .ack    (ack),
    .rdata  (rdata),
    .wdata  (wdata)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (plain integers)
  int          m_min, m_max, m_step, m_en, m_hold, m_state, m_out, m_hi, m_lo, m_cnt, m_ack;
  logic [31:0] m_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(input logic [13:0] v);
    return {{18{v[13]}}, v};
  endfunction

  function automatic int sx14(input logic [31:0] v);
    logic signed [13:0] s;
    s = v[13:0];
    return int'(s);
  endfunction

  function automatic int clampv(input int v);
    int r;
    r = v;
    if (r < m_min) r = m_min;
    if (r > m_max) r = m_max;
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    case (a)
      16'h0100: return 32'(m_min);
      16'h0104: return 32'(m_max);
      16'h0108: return 32'(m_step);
      16'h010C: return 32'(m_hold * 2 + m_en);
      16'h0110: return 32'(m_cnt * 65536 + m_lo * 8 + m_hi * 4 + m_state);
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_min = -8192; m_max = 8191; m_step = 0; m_en = 0; m_hold = 0; m_state = 0;
    m_out = 0; m_hi = 0; m_lo = 0; m_cnt = 0; m_ack = 0; m_rdata = '0;
  endtask

  // One rising edge of the specified behaviour, using the values held before the edge.
  task automatic model_step();
    int          din, t, nxt, ns;
    logic [31:0] rd;
    din = int'(dat_i);
    rd  = ren ? model_read(addr) : 32'd0;

    if (m_state == 1) begin
      t = clampv(din);
      if (m_step > 0 && t > m_out + m_step)      nxt = m_out + m_step;
      else if (m_step > 0 && t < m_out - m_step) nxt = m_out - m_step;
      else                                       nxt = t;
      nxt = clampv(nxt);
    end else if (m_state == 2) begin
      nxt = m_out;
    end else begin
      nxt = din;
    end

    if (m_state != 0) begin
      if (din > m_max) m_hi = 1;
      if (din < m_min) m_lo = 1;
      if ((din > m_max || din < m_min) && m_cnt < CntMax) m_cnt++;
    end

    if (m_en == 0)       ns = 0;
    else if (m_hold != 0) ns = 2;
    else                 ns = 1;

    if (wen) begin
      case (addr)
        16'h0100: m_min  = sx14(wdata);
        16'h0104: m_max  = sx14(wdata);
        16'h0108: m_step = int'(wdata[StepBits-1:0]);
        16'h010C: begin
          m_en   = int'(wdata[0]);
          m_hold = int'(wdata[1]);
          if (wdata[2]) begin
            m_cnt = 0; m_hi = 0; m_lo = 0;
          end
        end
        default: ;
      endcase
    end

    m_out   = nxt;
    m_state = ns;
    m_ack   = (wen || ren) ? 1 : 0;
    m_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    check_eq("dat_o", sx(dat_o), 32'(m_out));
    check_eq("ack", 32'(ack), 32'(m_ack));
    check_eq("rdata", rdata, m_rdata);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    tick();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] v);
    addr = a; ren = 1'b1;
    tick();
    v = rdata;
    ren = 1'b0;
  endtask

  // Called at a falling edge; asserts reset between clock edges.
  task automatic do_reset();
    rstn_i = 1'b0;
    #1;
    model_reset();
    check_eq("rst_dat_o", sx(dat_o), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  logic [31:0] v;
  int          seq_a[6] = '{10, 20, 30, 40, 50, 55};
  int          seq_b[3] = '{40, 50, 55};

  initial begin
    rstn_i = 1'b0; dat_i = '0; addr = '0; wen = 1'b0; ren = 1'b0; wdata = '0;
    model_reset();
    #2;
    check_eq("rst0_dat_o", sx(dat_o), 32'd0);
    check_eq("rst0_ack", 32'(ack), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Reset values and bypass latency
    rd(16'h0100, v); check_eq("min_rst", v, 32'hFFFF_E000);
    rd(16'h0104, v); check_eq("max_rst", v, 32'h0000_1FFF);
    dat_i = 14'sd1234;
    tick();
    check_eq("bypass_1234", sx(dat_o), 32'd1234);
    wr(16'h0104, 32'd100);
    check_eq("ack_wr104", 32'(ack), 32'd1);
    rd(16'h0104, v); check_eq("rd104", v, 32'd100);

    // Clamp and saturation flags
    wr(16'h0100, 32'(-100));
    dat_i = 14'sd5000;
    wr(16'h010C, 32'd1);
    repeat (3) tick();
    check_eq("clamp_hi", sx(dat_o), 32'd100);
    rd(16'h0110, v); check_eq("hi_flag", {28'd0, v[3:0]}, 32'h5);
    dat_i = -14'sd5000;
    repeat (2) tick();
    check_eq("clamp_lo", sx(dat_o), 32'(-100));
    rd(16'h0110, v); check_eq("lo_flag", 32'(v[3]), 32'd1);

    // Slew from zero
    dat_i = '0;
    wr(16'h010C, 32'd0);
    wr(16'h0100, 32'(-8192));
    wr(16'h0104, 32'd8191);
    wr(16'h0108, 32'd10);
    wr(16'h010C, 32'd1);
    tick();
    dat_i = 14'sd55;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("slew_up", sx(dat_o), 32'(seq_a[i]));
    end

    // Hold mid-slew at 30, then resume
    dat_i = '0;
    wr(16'h010C, 32'd0);
    wr(16'h010C, 32'd1);
    tick();
    dat_i = 14'sd55;
    tick();
    wr(16'h010C, 32'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_30", sx(dat_o), 32'd30);
    end
    wr(16'h010C, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("resume", sx(dat_o), 32'(seq_b[i]));
    end

    // Counter saturation and clear-wins
    wr(16'h0108, 32'd0);
    wr(16'h0104, 32'd100);
    wr(16'h0100, 32'(-100));
    dat_i = 14'sd5000;
    repeat (CntMax + 4) tick();
    rd(16'h0110, v); check_eq("cnt_sat", 32'(v[16 +: CntBits]), 32'(CntMax));
    wr(16'h010C, 32'd5);
    dat_i = '0;
    rd(16'h0110, v); check_eq("clear_wins", v, 32'h1);

    // Full-scale slew without wrap, then reset mid-slew
    wr(16'h010C, 32'd0);
    wr(16'h0100, 32'(-8192));
    wr(16'h0104, 32'd8191);
    wr(16'h0108, 32'd4000);
    dat_i = 14'sd8000;
    tick();
    wr(16'h010C, 32'd1);
    tick();
    dat_i = 14'sd8191;
    tick();
    check_eq("no_wrap", sx(dat_o), 32'd8191);
    dat_i = -14'sd8192;
    tick();
    check_eq("slew_down", sx(dat_o), 32'd4191);
    do_reset();
    dat_i = 14'sd77;
    tick();
    check_eq("post_rst_bypass", sx(dat_o), 32'd77);
    rd(16'h010C, v); check_eq("post_rst_ctrl", v, 32'd0);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      int unsigned r;
      dat_i = 14'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        case ($urandom_range(0, 3))
          0: wr(16'h0100, ($urandom_range(0, 1) != 0) ? $urandom
                                                      : 32'(int'($urandom_range(0, 6000)) - 3000));
          1: wr(16'h0104, ($urandom_range(0, 1) != 0) ? $urandom
                                                      : 32'(int'($urandom_range(0, 6000)) - 3000));
          2: wr(16'h0108, ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 400)));
          default: wr(16'h010C, 32'($urandom_range(0, 7)));
        endcase
      end else if (r == 1) begin
        case ($urandom_range(0, 6))
          0: rd(16'h0100, v);
          1: rd(16'h0104, v);
          2: rd(16'h0108, v);
          3: rd(16'h010C, v);
          4: rd(16'h0110, v);
          5: rd(16'h0114, v);
          default: rd(16'($urandom), v);
        endcase
      end else if (r == 2 && $urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/red_pitaya_haze_limiter.md
RED_PITAYA_HAZE_LIMITER -- requirements
Module: red_pitaya_haze_limiter

Interface
REQ-001 Parameter CNTBITS, default 16: width of the saturation event counter.
REQ-002 Parameter STEPBITS, default 13: width of the unsigned slew step register.
REQ-003 Ports, in order: clk_i input 1 clock; rstn_i input 1 reset; dat_i input 14 signed sample from the haze mixing stage; dat_o output 14 signed limited sample to the DAC path; addr input 16 bus address; wen input 1 write strobe; ren input 1 read strobe; ack output 1 bus acknowledge; rdata output 32 read data; wdata input 32 write data.
REQ-004 The block SHALL use one clock, clk_i; rstn_i SHALL be an asynchronous, active-low reset.

Function -- register map, all registers acknowledged
REQ-005 0x100 MIN: 14-bit signed lower limit, wdata[13:0]; reads back sign-extended to 32 bits.
REQ-006 0x104 MAX: 14-bit signed upper limit, wdata[13:0]; reads back sign-extended to 32 bits.
REQ-007 0x108 STEP: unsigned wdata[STEPBITS-1:0]; 0 means no slew limit.
REQ-008 0x10C CTRL: bit0 ENABLE, bit1 HOLD; bit2 CLEAR is a self-clearing pulse that zeroes the counter and flags; reads return {bit1 HOLD, bit0 ENABLE}.
REQ-009 0x110 STATUS, read-only: [1:0] state code, bit2 sticky HI flag, bit3 sticky LO flag, [16+CNTBITS-1:16] saturation count.
REQ-010 ack SHALL assert exactly one cycle after any cycle with wen|ren, for every address.
REQ-011 rdata SHALL be registered and valid in the same cycle as ack; unmapped addresses return 0.

Function -- state machine, 2-bit code
REQ-012 States: BYPASS=0, TRACK=1, HOLD=2.
REQ-013 BYPASS -> TRACK when ENABLE=1 and HOLD=0.
REQ-014 BYPASS -> HOLD when ENABLE=1 and HOLD=1.
REQ-015 TRACK <-> HOLD following the HOLD bit.
REQ-016 Any state -> BYPASS when ENABLE=0.
REQ-017 A transition SHALL take effect on the cycle after the CTRL write acknowledge edge.

Function -- datapath, one-cycle latency from dat_i to dat_o
REQ-018 BYPASS: dat_o <= dat_i.
REQ-019 Target T = clamp(dat_i, MIN, MAX); MAX is applied last, so T=MAX when MIN>MAX.
REQ-020 TRACK with STEP=0: dat_o <= T.
REQ-021 TRACK with STEP>0 and T > dat_o+STEP: dat_o <= dat_o+STEP.
REQ-022 TRACK with STEP>0 and T < dat_o-STEP: dat_o <= dat_o-STEP.
REQ-023 TRACK with STEP>0 otherwise: dat_o <= T.
REQ-024 Slew arithmetic SHALL be computed at 16-bit signed width and the result clamped to [MIN, MAX]; there is no wrap-around at +8191 or -8192.
REQ-025 HOLD: dat_o SHALL keep its value.
REQ-026 On entering TRACK from BYPASS, slewing starts from the current dat_o.
REQ-027 In TRACK and HOLD, a cycle with dat_i>MAX SHALL set HI and increment the counter.
REQ-028 In TRACK and HOLD, a cycle with dat_i<MIN SHALL set LO and increment the counter.
REQ-029 The counter SHALL saturate at all-ones and not wrap.
REQ-030 If CLEAR coincides with a saturation event, the clear wins: the counter reads 0 and both flags read 0.

Reset
REQ-031 While rstn_i=0, regardless of clock: dat_o=0, ack=0, rdata=0, MIN=-8192, MAX=+8191, STEP=0, ENABLE=0, HOLD=0, state=BYPASS, counter=0, flags=0.
REQ-032 Reset asserted mid-operation SHALL abort any slew immediately.
REQ-033 After reset release, the block SHALL resume in BYPASS on the next clock edge.

Verification
REQ-034 Reset then dat_i=1234 -> dat_o=1234 one cycle later; write/read of 0x104 acks one cycle after the strobe.
REQ-035 MIN=-100, MAX=100, ENABLE=1, dat_i=5000 -> dat_o=100, HI=1, counter increments once per cycle; dat_i=-5000 -> dat_o=-100, LO=1.
REQ-036 STEP=10, ENABLE=1, dat_o=0, dat_i=55 -> dat_o sequence 10, 20, 30, 40, 50, 55.
REQ-037 HOLD=1 while slewing at 30 -> dat_o stays 30; HOLD=0 -> slewing resumes 40, 50, 55.
REQ-038 Counter preset to all-ones with dat_i out of range -> count stays all-ones; CLEAR on the same cycle as an event -> count 0, flags 0.
REQ-039 MAX=8191, STEP=4000, dat_o=8000, dat_i=8191 -> dat_o=8191 with no wrap; reset asserted mid-slew -> dat_o=0 asynchronously.
